id_stage: RTL

// - Pipelined RV32I decode stage: full immediate generation (I/S/B/U/J/shamt), 2R1W regfile

---
 rtl/id_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: immediate generation, 2R1W regfile (x0 = 0), load-use stall, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle writeback into the captured operands.
module id_stage #(
   parameter int XLEN        = 32,
   parameter int PC_SIZE     = 32,
   parameter int RFIDX_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_SIZE-1:0]     in_pc,
   input  logic [31:0]            in_instr,
   input  logic                   flush,
   input  logic                   ex_is_load,
   input  logic [RFIDX_WIDTH-1:0] ex_rd,
   input  logic                   wb_we,
   input  logic [RFIDX_WIDTH-1:0] wb_idx,
   input  logic [XLEN-1:0]        wb_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_SIZE-1:0]     out_pc,
   output logic [XLEN-1:0]        out_rs1_data,
   output logic [XLEN-1:0]        out_rs2_data,
   output logic [XLEN-1:0]        out_imm,
   output logic [3:0]             out_alu_funct,
   output logic [6:0]             out_opcode,
   output logic [RFIDX_WIDTH-1:0] out_rd,
   output logic [RFIDX_WIDTH-1:0] out_rs1,
   output logic [RFIDX_WIDTH-1:0] out_rs2,
   output logic                   out_reg_we
);

   localparam int NREGS = 2 ** RFIDX_WIDTH;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_e;

   logic [XLEN-1:0] rf_q [NREGS];

   // Instruction fields
   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic [RFIDX_WIDTH-1:0] rd, rs1, rs2;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign rd     = in_instr[7 +: RFIDX_WIDTH];
   assign rs1    = in_instr[15 +: RFIDX_WIDTH];
   assign rs2    = in_instr[20 +: RFIDX_WIDTH];

   logic            rs1_used, rs2_used, reg_we, stall, accept;
   logic [XLEN-1:0] imm;
   logic [3:0]      alu_funct;
   logic [XLEN-1:0] rs1_rd_data, rs2_rd_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      reg_we    = 1'b0;
      imm       = '0;
      alu_funct = {1'b0, funct3};
      unique case (opcode)
         OPC_OP: begin
            rs1_used     = 1'b1;
            rs2_used     = 1'b1;
            reg_we       = 1'b1;
            alu_funct[3] = in_instr[30];
         end
         OPC_OP_IMM: begin
            rs1_used = 1'b1;
            reg_we   = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101)
               imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            else
               imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            if (funct3 == 3'b101) alu_funct[3] = in_instr[30];
         end
         OPC_LOAD, OPC_JALR: begin
            rs1_used = 1'b1;
            reg_we   = 1'b1;
            imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
         end
         OPC_STORE: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OPC_BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            imm      = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            reg_we = 1'b1;
            imm    = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
         end
         OPC_JAL: begin
            reg_we = 1'b1;
            imm    = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
         end
         default: ;
      endcase
      if (rd == '0) reg_we = 1'b0;
   end

   // Combinational read; x0 returns zero regardless of array content.
   always_comb begin
      rs1_rd_data = (rs1 == '0) ? '0 : rf_q[rs1];
      rs2_rd_data = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef ID_WB_BYPASS_EN
      if (wb_we && wb_idx != '0 && wb_idx == rs1) rs1_rd_data = wb_data;
      if (wb_we && wb_idx != '0 && wb_idx == rs2) rs2_rd_data = wb_data;
`endif
   end

   assign stall = in_valid && ex_is_load && (ex_rd != '0) &&
                  ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
   assign in_ready = (!out_valid || out_ready) && !stall;
   assign accept   = in_valid && in_ready;

   // NOTE: the regfile is reset entry by entry because reset must leave every register at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_we && wb_idx != '0) begin
         rf_q[wb_idx] <= wb_data;
      end
   end

   logic valid_q, valid_d;

   always_comb begin
      valid_d = valid_q;
      if (flush)                    valid_d = 1'b0;
      else if (accept)              valid_d = 1'b1;
      else if (valid_q && out_ready) valid_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         out_pc        <= '0;
         out_rs1_data  <= '0;
         out_rs2_data  <= '0;
         out_imm       <= '0;
         out_alu_funct <= '0;
         out_opcode    <= '0;
         out_rd        <= '0;
         out_rs1       <= '0;
         out_rs2       <= '0;
         out_reg_we    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            out_pc        <= in_pc;
            out_rs1_data  <= rs1_rd_data;
            out_rs2_data  <= rs2_rd_data;
            out_imm       <= imm;
            out_alu_funct <= alu_funct;
            out_opcode    <= opcode;
            out_rd        <= rd;
            out_rs1       <= rs1;
            out_rs2       <= rs2;
            out_reg_we    <= reg_we;
         end
      end
   end

   assign out_valid = valid_q;

endmodule
